instruction_encoder: RTL
========================

Name: instruction_encoder

Overview:
Inverse of the instruction decoder. Accepts one decoded-field record per handshake and packs it into a 32-bit ARM-style word using the same field layout the decoder splits apart. Emits each word with a sequential program address for loading into instruction memory. Data-processing immediates are legality-checked by a multi-cycle rotate search; unencodable inputs raise an error instead of producing a word.

Parameters:
ADDR_W, 8, width of program word address counter (wraps at 2^ADDR_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  field record valid
in_ready  out  1  encoder can accept (high only in IDLE)
in_optype  in  2  00 data-proc, 01 memory, 10 branch, 11 illegal
in_cond  in  4  condition field [31:28]
in_cmd  in  4  DP opcode [24:21]; memory: bit0=L (load), bit1=B (byte)
in_s  in  1  DP S bit [20]
in_rn, in_rd, in_rm, in_rs  in  4 each  register fields
in_src2_imm  in  1  DP: Src2 is immediate
in_imm32  in  32  DP immediate value, or memory offset (two's complement)
in_shift_type  in  2  shift type [6:5]
in_shift_reg  in  1  1: shift by Rs, 0: by in_shift_amt
in_shift_amt  in  5  immediate shift amount [11:7]
in_link  in  1  branch L bit [24]
in_boffset  in  24  branch offset [23:0]
out_valid  out  1  encoded word valid
out_ready  in  1  downstream accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  program address of out_instr
err_valid  out  1  one-cycle error pulse
err_code  out  2  1 imm unencodable, 2 mem offset range, 3 illegal optype
addr_clr  in  1  synchronous clear of address counter (ignored while OUT)

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_instr=0, out_addr=0, err_valid=0, err_code=0. Reset mid-operation discards the captured record; no word or error is emitted.
- States: IDLE, SEARCH, OUT, ERR.
- IDLE: in_ready=1. On in_valid, capture all fields. Next state:
  - ERR for optype 11 or |memory offset| > 4095.
  - SEARCH for DP with in_src2_imm=1.
  - OUT otherwise (latency 1).
- SEARCH: rot r counts 0..15, one value per cycle. Test whether (imm32 ROL 2r)[31:8]==0.
  - First hit: imm8=(imm32 ROL 2r)[7:0], Src2={r[3:0],imm8}, go OUT. Smallest r always wins. Latency = r+2 cycles after accept.
  - r=15 with no hit: go ERR with code 1.
- Encoding, all types: [31:28]=cond, [27:26]=optype.
  - DP: [25]=src2_imm, [24:21]=cmd, [20]=S, [19:16]=Rn, [15:12]=Rd. Register Src2: [11:7]=shamt,[6:5]=type,[4]=0,[3:0]=Rm; or, when shifting by register, [11:8]=Rs,[7]=0,[6:5]=type,[4]=1,[3:0]=Rm.
  - MEM: [25]=0, [24]=P=1, [23]=U=(offset>=0), [22]=B, [21]=W=0, [20]=L, Rn, Rd, [11:0]=|offset|.
  - BR: [25]=1, [24]=L, [23:0]=offset.
- OUT: out_valid=1; out_instr/out_addr held stable until out_ready. On out_ready, out_addr increments (modulo 2^ADDR_W) and state returns to IDLE. in_ready=0 throughout.
- ERR: err_valid=1 for exactly one cycle with err_code. No word is emitted and out_addr is unchanged. Next state is IDLE; err_code holds until the next error.
- addr_clr in IDLE/SEARCH/ERR zeroes the counter the next cycle. When a clear coincides with the IDLE accept, the clear applies first.

Decomposition:
- encoder_pkg: optype enum (OP_DP, OP_MEM, OP_BR, OP_ILL), COND_AL=4'hE, err_code constants, state enum.
- Sub-module arm_imm_fit: combinational (imm32, r) -> (fits, imm8). Instantiated once and driven by the SEARCH counter.

Test Plan:
- Reset, then SUBS R3,R4,R5 LSL #2 (DP, cmd=0010, S=1, cond E) -> out_instr=0xE0543105, out_addr=0, out_valid 1 cycle after accept.
- ADD R1,R2,#0x3F0 -> rot=14, out_instr=0xE2821E3F, out_valid 16 cycles after accept, out_addr=1.
- LDR R0,[R1,#-4] -> 0xE5110004; BL offset 0x000010 cond E -> 0xEB000010; out_addr advances 2,3.
- DP imm 0x101 -> err_valid pulse, code 1, no out_valid, out_addr unchanged. Memory offset 5000 -> code 2. Optype 11 -> code 3.
- Hold out_ready=0 for 5 cycles in OUT -> out_instr/out_addr stable, in_ready=0; release -> single transfer. Fill counter with ADDR_W=2: 4 words -> out_addr wraps to 0.
- Assert rst during SEARCH -> all outputs zero next cycle, no word or error emitted. addr_clr after 3 words -> next word at out_addr 0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types, constants and field-packing helpers for the ARM-style instruction encoder.
package encoder_pkg;

  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_IMM       = 2'd1;
  localparam logic [1:0] ERR_MEM_RANGE = 2'd2;
  localparam logic [1:0] ERR_OPTYPE    = 2'd3;

  localparam logic [31:0] MEM_OFF_MAX = 32'd4095;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } opType_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_OUT,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  optype;
    logic [3:0]  cmd;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic        src2Imm;
    logic [31:0] imm32;
    logic [1:0]  shiftType;
    logic        shiftReg;
    logic [4:0]  shiftAmt;
    logic        link;
    logic [23:0] bOffset;
  } fieldRec_t;

  // Magnitude of a two's-complement memory offset.
  function automatic logic [31:0] memMag(input logic [31:0] off);
    return off[31] ? (~off + 32'd1) : off;
  endfunction

  // immSrc2 is the {rot, imm8} pair found by the search; only used for DP immediates.
  function automatic logic [31:0] encodeWord(input fieldRec_t f, input logic [11:0] immSrc2);
    logic [31:0] w;
    logic [31:0] mag;
    w       = '0;
    mag     = memMag(f.imm32);
    w[31:28] = f.cond;
    w[27:26] = f.optype;
    case (f.optype)
      OP_DP: begin
        w[25]    = f.src2Imm;
        w[24:21] = f.cmd;
        w[20]    = f.s;
        w[19:16] = f.rn;
        w[15:12] = f.rd;
        if (f.src2Imm) begin
          w[11:0] = immSrc2;
        end else if (f.shiftReg) begin
          w[11:8] = f.rs;
          w[7]    = 1'b0;
          w[6:5]  = f.shiftType;
          w[4]    = 1'b1;
          w[3:0]  = f.rm;
        end else begin
          w[11:7] = f.shiftAmt;
          w[6:5]  = f.shiftType;
          w[4]    = 1'b0;
          w[3:0]  = f.rm;
        end
      end
      OP_MEM: begin
        w[25]    = 1'b0;
        w[24]    = 1'b1;
        w[23]    = ~f.imm32[31];
        w[22]    = f.cmd[1];
        w[21]    = 1'b0;
        w[20]    = f.cmd[0];
        w[19:16] = f.rn;
        w[15:12] = f.rd;
        w[11:0]  = mag[11:0];
      end
      OP_BR: begin
        w[25]   = 1'b1;
        w[24]   = f.link;
        w[23:0] = f.bOffset;
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/arm_imm_fit.sv
// Checks whether a 32-bit value is an 8-bit constant rotated right by 2*rot.
module arm_imm_fit
  import encoder_pkg::*;
(
  input  logic [31:0] imm32,
  input  logic [3:0]  rot,
  output logic        fits,
  output logic [7:0]  imm8
);

  logic [4:0]  shAmt;
  logic [5:0]  backAmt;
  logic [31:0] rotated;

  // Rotating left by 2*rot undoes the encoding's rotate right; shift by 32 yields 0.
  always_comb begin
    shAmt   = {rot, 1'b0};
    backAmt = 6'd32 - {1'b0, shAmt};
    rotated = (imm32 << shAmt) | (imm32 >> backAmt);
    fits    = (rotated[31:8] == 24'd0);
    imm8    = rotated[7:0];
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into 32-bit ARM-style words with sequential program addresses.
module instruction_encoder
  import encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_optype,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic [3:0]        in_rs,
  input  logic              in_src2_imm,
  input  logic [31:0]       in_imm32,
  input  logic [1:0]        in_shift_type,
  input  logic              in_shift_reg,
  input  logic [4:0]        in_shift_amt,
  input  logic              in_link,
  input  logic [23:0]       in_boffset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  input  logic              addr_clr
);

  state_t    state, nextState;
  fieldRec_t inRec, capRec;
  opType_t   inOp;
  logic      accept;
  logic [3:0] rot;
  logic      fits;
  logic [7:0] imm8;
  logic [1:0] idleErrCode;

  assign inOp  = opType_t'(in_optype);
  assign inRec = '{cond: in_cond, optype: in_optype, cmd: in_cmd, s: in_s,
                   rn: in_rn, rd: in_rd, rm: in_rm, rs: in_rs,
                   src2Imm: in_src2_imm, imm32: in_imm32,
                   shiftType: in_shift_type, shiftReg: in_shift_reg,
                   shiftAmt: in_shift_amt, link: in_link, bOffset: in_boffset};

  assign accept      = (state == S_IDLE) && in_valid;
  assign idleErrCode = (inOp == OP_ILL) ? ERR_OPTYPE : ERR_MEM_RANGE;

  arm_imm_fit u_immFit (
    .imm32 (capRec.imm32),
    .rot   (rot),
    .fits  (fits),
    .imm8  (imm8)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (inOp == OP_ILL || (inOp == OP_MEM && memMag(in_imm32) > MEM_OFF_MAX))
            nextState = S_ERR;
          else if (inOp == OP_DP && in_src2_imm)
            nextState = S_SEARCH;
          else
            nextState = S_OUT;
        end
      end
      S_SEARCH: begin
        if (fits)             nextState = S_OUT;
        else if (rot == 4'hF) nextState = S_ERR;
      end
      S_OUT:   if (out_ready) nextState = S_IDLE;
      S_ERR:   nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_OUT);
    err_valid = (state == S_ERR);
  end

  // Capture stage: the record is only read while searching, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) capRec <= inRec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      rot <= 4'd0;
    else if (accept)              rot <= 4'd0;
    else if (state == S_SEARCH)   rot <= rot + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_instr <= 32'd0;
    else if (accept && nextState == S_OUT)
      out_instr <= encodeWord(inRec, 12'h000);
    else if (state == S_SEARCH && fits)
      out_instr <= encodeWord(capRec, {rot, imm8});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_code <= ERR_NONE;
    else if (nextState == S_ERR && state != S_ERR)
      err_code <= (state == S_SEARCH) ? ERR_IMM : idleErrCode;
  end

  // A clear outside OUT wins over everything, including a same-cycle accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_addr <= '0;
    else if (state != S_OUT && addr_clr)
      out_addr <= '0;
    else if (state == S_OUT && out_ready)
      out_addr <= out_addr + 1'b1;
  end

endmodule
